gravador_sequencia: RTL and testbench

- Records a sequence of player key presses (one-hot `chaves`) into an internal 16x4 memory, one entry per press/release cycle.
- Stops when 16 entries are stored or `finalizar` is asserted.
- Is the writer counterpart of the game's sequence checker: the checker reads what this block stores, through the asynchronous read port.
- Contains its own control FSM, address/length counter, key register and RAM.

---
 rtl/gravador_sequencia.sv | 135 +++++++++++++
 tb/tb_gravador_sequencia.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gravador_sequencia.sv
// Records one-hot key presses into a 16x4 RAM, one entry per press/release; optional idle timeout under GRAVADOR_TIMEOUT_EN.
// Key reaches the RAM 2 cycles after leaving ESPERA_JOGADA; no backpressure, inputs are levels sampled every cycle.
module gravador_sequencia #(
  parameter int TIMEOUT = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic [3:0] chaves,
  input  logic       finalizar,
  input  logic [3:0] endereco_leitura,
  output logic [3:0] dado_leitura,
  output logic [4:0] tamanho,
  output logic       gravando,
  output logic       pronto,
  output logic       erro,
  output logic       timeout,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARACAO    = 4'h1,
    ESPERA_JOGADA = 4'h2,
    REGISTRA      = 4'h3,
    GRAVA         = 4'h4,
    ESPERA_SOLTA  = 4'h5,
    FIM           = 4'h6,
    ERRO          = 4'hE
  } estado_t;

  estado_t     estado, proximo;
  logic [3:0]  chave_reg;
  logic [4:0]  tam;
  logic [3:0]  mem [16];
  logic        expirou;
  logic        chave_valida;
  logic        cheio;

  assign chave_valida = (chave_reg != 4'd0) && ((chave_reg & (chave_reg - 4'd1)) == 4'd0);
  assign cheio        = (tam == 5'd16);

`ifdef GRAVADOR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] ocioso;
  logic          timeout_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ocioso <= '0;
    end else if (estado == ESPERA_JOGADA) begin
      ocioso <= ocioso + 1'b1;
    end else begin
      ocioso <= '0;
    end
  end

  assign expirou = (estado == ESPERA_JOGADA) && (ocioso == CW'(TIMEOUT - 1));

  // Remembers the cause of the error for as long as ERRO is held.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      timeout_reg <= 1'b0;
    end else if (estado != ERRO && proximo == ERRO) begin
      timeout_reg <= (estado == ESPERA_JOGADA);
    end else if (estado == ERRO && proximo != ERRO) begin
      timeout_reg <= 1'b0;
    end
  end

  assign timeout = timeout_reg && (estado == ERRO);
`else
  logic unused_timeout_param;
  assign unused_timeout_param = |TIMEOUT;
  assign expirou = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado <= INICIAL;
    end else begin
      estado <= proximo;
    end
  end

  always_comb begin
    proximo = estado;
    case (estado)
      INICIAL:       if (iniciar) proximo = PREPARACAO;
      PREPARACAO:    proximo = ESPERA_JOGADA;
      ESPERA_JOGADA: begin
        if (chaves != 4'd0)                 proximo = REGISTRA;
        else if (finalizar && tam != 5'd0)  proximo = FIM;
        else if (expirou)                   proximo = ERRO;
      end
      REGISTRA:      proximo = chave_valida ? GRAVA : ERRO;
      GRAVA:         proximo = ESPERA_SOLTA;
      ESPERA_SOLTA:  if (chaves == 4'd0) proximo = cheio ? FIM : ESPERA_JOGADA;
      FIM, ERRO:     if (iniciar) proximo = PREPARACAO;
      default:       proximo = INICIAL;
    endcase
  end

  // Length is cleared on the way into PREPARACAO so the new session shows 0 at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tam       <= 5'd0;
      chave_reg <= 4'd0;
    end else if (proximo == PREPARACAO || estado == PREPARACAO) begin
      tam       <= 5'd0;
      chave_reg <= 4'd0;
    end else if (estado == ESPERA_JOGADA && chaves != 4'd0) begin
      chave_reg <= chaves;
    end else if (estado == GRAVA && !cheio) begin
      tam <= tam + 5'd1;
    end
  end

  // RAM has no reset: contents survive reset and new sessions.
  always_ff @(posedge clock) begin
    if (estado == GRAVA && !cheio) begin
      mem[tam[3:0]] <= chave_reg;
    end
  end

  assign dado_leitura = mem[endereco_leitura];
  assign tamanho      = tam;
  assign gravando     = (estado == PREPARACAO) || (estado == ESPERA_JOGADA) ||
                        (estado == REGISTRA) || (estado == GRAVA) || (estado == ESPERA_SOLTA);
  assign pronto       = (estado == FIM);
  assign erro         = (estado == ERRO);
  assign db_estado    = estado;

endmodule

// File: tb/tb_gravador_sequencia.sv
// Bench for gravador_sequencia: directed vector table, hand-written corner sequences,
// then random sessions scored against a transaction-level model of the recorded sequence.
module tb_gravador_sequencia;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic       finalizar;
  logic [3:0] endereco_leitura;
  logic [3:0] dado_leitura;
  logic [4:0] tamanho;
  logic       gravando, pronto, erro, timeout;
  logic [3:0] db_estado;

  gravador_sequencia #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .finalizar(finalizar), .endereco_leitura(endereco_leitura),
    .dado_leitura(dado_leitura), .tamanho(tamanho), .gravando(gravando),
    .pronto(pronto), .erro(erro), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       ini;
    logic       fin;
    logic [3:0] ch;
    logic [3:0] est;
    logic [4:0] tam;
  } vec_t;

  vec_t       tbl[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] shadow [16];
  logic       known  [16];
  logic [3:0] q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic row(input logic ini, input logic fin, input logic [3:0] ch,
                     input logic [3:0] est, input logic [4:0] tam);
    vec_t v;
    v.ini = ini; v.fin = fin; v.ch = ch; v.est = est; v.tam = tam;
    tbl.push_back(v);
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    tick();
  endtask

  task automatic check_mem(input string nm);
    for (int a = 0; a < 16; a++) begin
      if (known[a]) begin
        endereco_leitura = 4'(a);
        #1;
        chk($sformatf("%s_rd%0d", nm, a), dado_leitura, shadow[a]);
      end
    end
  endtask

  task automatic check_state(input string nm, input logic [3:0] est, input logic [4:0] tam);
    chk({nm, "_estado"}, db_estado, est);
    chk({nm, "_tamanho"}, tamanho, tam);
    chk({nm, "_gravando"}, gravando, (est >= 4'd1 && est <= 4'd5));
    chk({nm, "_pronto"}, pronto, (est == 4'd6));
    chk({nm, "_erro"}, erro, (est == 4'hE));
  endtask

  initial begin
    logic [3:0] k;
    logic       done, bad;
    int         h, g, r;

    reset = 1'b0; iniciar = 1'b0; chaves = 4'd0; finalizar = 1'b0; endereco_leitura = 4'd0;
    for (int a = 0; a < 16; a++) begin known[a] = 1'b0; shadow[a] = 4'd0; end

    // basic recording 1,2,4 then finalizar
    row(1,0,4'h0,4'h1,0); row(0,0,4'h0,4'h2,0);
    row(0,0,4'h1,4'h3,0); row(0,0,4'h0,4'h4,0); row(0,0,4'h0,4'h5,1); row(0,0,4'h0,4'h2,1);
    row(0,0,4'h2,4'h3,1); row(0,0,4'h0,4'h4,1); row(0,0,4'h0,4'h5,2); row(0,0,4'h0,4'h2,2);
    row(0,0,4'h4,4'h3,2); row(0,0,4'h0,4'h4,2); row(0,0,4'h0,4'h5,3); row(0,0,4'h0,4'h2,3);
    row(0,1,4'h0,4'h6,3); row(0,0,4'h0,4'h6,3);
    // restart, invalid key 0011
    row(1,0,4'h0,4'h1,0); row(0,0,4'h0,4'h2,0);
    row(0,0,4'h3,4'h3,0); row(0,0,4'h0,4'hE,0); row(0,0,4'h0,4'hE,0);
    row(1,0,4'h0,4'h1,0); row(0,0,4'h0,4'h2,0);
    // finalizar with nothing stored, key+finalizar together, key held 10 cycles
    row(0,1,4'h0,4'h2,0); row(0,1,4'h4,4'h3,0); row(0,0,4'h4,4'h4,0);
    for (int i = 0; i < 8; i++) row(0,0,4'h4,4'h5,1);
    row(0,0,4'h0,4'h2,1);
    row(0,1,4'h0,4'h6,1); row(0,0,4'h0,4'h6,1);

    repeat (3) @(posedge clock);
    #1;
    check_state("reset", 4'h0, 5'd0);
    chk("reset_timeout", timeout, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    tick();
    chk("idle_estado", db_estado, 4'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      iniciar = tbl[i].ini; finalizar = tbl[i].fin; chaves = tbl[i].ch;
      tick();
      check_state($sformatf("row%0d", i), tbl[i].est, tbl[i].tam);
      chk($sformatf("row%0d_timeout", i), timeout, 1'b0);
      if (i == 15) begin
        shadow[0] = 4'h1; shadow[1] = 4'h2; shadow[2] = 4'h4;
        known[0] = 1'b1; known[1] = 1'b1; known[2] = 1'b1;
        check_mem("basic");
      end
    end
    iniciar = 1'b0; finalizar = 1'b0; chaves = 4'd0;
    shadow[0] = 4'h4;
    check_mem("held");

    // full memory: release after 16th press goes straight to FIM
    start();
    for (int i = 0; i < 16; i++) begin
      chaves = 4'h8; tick();
      chaves = 4'h0; repeat (3) tick();
      shadow[i] = 4'h8; known[i] = 1'b1;
    end
    check_state("full", 4'h6, 5'd16);
    check_mem("full");

    // idle in ESPERA_JOGADA for 8 cycles
    start();
    repeat (8) tick();
`ifdef GRAVADOR_TIMEOUT_EN
    check_state("tmo", 4'hE, 5'd0);
    chk("tmo_timeout", timeout, 1'b1);
    start();
    chk("tmo_cleared", timeout, 1'b0);
`else
    check_state("tmo", 4'h2, 5'd0);
    chk("tmo_timeout", timeout, 1'b0);
`endif

    // reset during GRAVA
    chaves = 4'h2; tick();
    chk("mid_reg", db_estado, 4'h3);
    chaves = 4'h0; tick();
    chk("mid_grava", db_estado, 4'h4);
    #2 reset = 1'b0;
    #1;
    check_state("midrst", 4'h0, 5'd0);
    check_mem("midrst");
    @(negedge clock);
    reset = 1'b1;
    tick();

    // random sessions against a sequence-level model
    for (int s = 0; s < 40; s++) begin
      start();
      q.delete();
      done = 1'b0; bad = 1'b0;
      while (!done) begin
        r = $urandom_range(0, 11);
        if (r == 0) begin
          finalizar = 1'b1; tick(); finalizar = 1'b0;
          if (q.size() > 0) done = 1'b1;
        end else if (r == 1) begin
          do k = 4'($urandom_range(3, 15)); while ($countones(k) < 2);
          chaves = k; tick();
          chaves = 4'h0; repeat (2) tick();
          done = 1'b1; bad = 1'b1;
        end else begin
          k = 4'h1 << $urandom_range(0, 3);
          h = $urandom_range(1, 4);
          chaves = k; finalizar = 1'($urandom_range(0, 1)); tick();
          finalizar = 1'b0;
          for (int j = 1; j < h; j++) begin
            chaves = 4'($urandom_range(1, 15)); tick();
          end
          chaves = 4'h0;
          g = ((4 - h) > 1 ? (4 - h) : 1) + $urandom_range(0, 2);
          repeat (g) tick();
          shadow[q.size()] = k; known[q.size()] = 1'b1;
          q.push_back(k);
          if (q.size() == 16) done = 1'b1;
        end
      end
      check_state($sformatf("rnd%0d", s), bad ? 4'hE : 4'h6, 5'(q.size()));
      chk($sformatf("rnd%0d_timeout", s), timeout, 1'b0);
      check_mem($sformatf("rnd%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
